cook_sequencer: RTL and testbench

Cook-cycle sequencer for the microwave oven. It accepts keypad time entry as four BCD digits (mm:ss) and runs the countdown once a start is requested with the door closed. It drives the magnetron enable and pauses on stop or door-open. It raises `timer_done` at 00:00, and the existing control logic consumes that signal, so this block is the source of `timer_done`.

---
 rtl/cook_pkg.sv | 22 ++
 rtl/bcd_mmss_dec.sv | 33 +++
 rtl/cook_sequencer.sv | 141 ++++++++++++++
 tb/tb_cook_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook-cycle sequencer.
package cook_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } cook_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int MAX_LEVEL     = 10;
   localparam int SLOTS_PER_SEC = 10;

   // Out-of-range power levels run at full power.
   function automatic logic [3:0] clamp_level(input logic [3:0] lv);
      return (lv == 4'd0 || lv > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : lv;
   endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD mm:ss value, with zero flag on the result.
module bcd_mmss_dec
   import cook_pkg::*;
(
   input  logic [15:0] time_in,
   output logic [15:0] time_out,
   output logic        zero
);

   bcd_digit_t m10, m1, s10, s1;

   // Seconds tens reload 5 on borrow; s10 itself is never range-checked.
   always_comb begin
      {m10, m1, s10, s1} = time_in;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
         s1 = 4'd9;
         if (s10 != 4'd0) s10 = s10 - 4'd1;
         else begin
            s10 = 4'd5;
            if (m1 != 4'd0) m1 = m1 - 4'd1;
            else begin
               m1  = 4'd9;
               m10 = m10 - 4'd1;
            end
         end
      end
      time_out = {m10, m1, s10, s1};
   end

   assign zero = (time_out == 16'h0000);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad mm:ss entry, countdown, pause/resume, timer_done pulse.
// Optional duty-cycled magnetron power levels under `COOK_POWER_LEVEL_EN.
module cook_sequencer
   import cook_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        startn,
   input  logic        stopn,
   input  logic        clrn,
   input  logic        door_closed,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic [3:0]  power_level,
   output logic        mag_on,
   output logic [15:0] time_bcd,
   output logic        timer_done,
   output logic        cooking,
   output logic        paused
);

   localparam int PW = $clog2(TICKS_PER_SEC);

   cook_state_t   state, state_nxt;
   logic [15:0]   time_nxt, dec_time;
   logic [PW-1:0] presc, presc_nxt;
   logic          start_prev, stop_prev, start_ev, stop_ev;
   logic          dec_zero, wrap, done_nxt, mag_nxt;

   assign start_ev = start_prev & ~startn;
   assign stop_ev  = stop_prev  & ~stopn;
   assign wrap     = (presc == PW'(TICKS_PER_SEC - 1));

   bcd_mmss_dec u_dec (
      .time_in  (time_bcd),
      .time_out (dec_time),
      .zero     (dec_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         time_bcd   <= '0;
         presc      <= '0;
         start_prev <= 1'b1;
         stop_prev  <= 1'b1;
         mag_on     <= 1'b0;
         timer_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         time_bcd   <= time_nxt;
         presc      <= presc_nxt;
         start_prev <= startn;
         stop_prev  <= stopn;
         mag_on     <= mag_nxt;
         timer_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      time_nxt  = time_bcd;
      presc_nxt = presc;
      done_nxt  = 1'b0;
      if (!clrn) begin
         state_nxt = IDLE;
         time_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid && key_digit <= 4'd9) begin
                  state_nxt = SET;
                  time_nxt  = {time_bcd[11:0], key_digit};
               end
            end
            SET: begin
               if (start_ev && door_closed && time_bcd != '0) begin
                  state_nxt = COOK;
                  presc_nxt = '0;
               end else if (key_valid && key_digit <= 4'd9) begin
                  time_nxt = {time_bcd[11:0], key_digit};
               end
            end
            COOK: begin
               // A wrap always lands the decrement, even when pausing the same cycle.
               if (wrap) begin
                  presc_nxt = '0;
                  time_nxt  = dec_time;
               end else if (door_closed && !stop_ev) begin
                  presc_nxt = presc + PW'(1);
               end
               if (wrap && dec_zero) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else if (!door_closed || stop_ev) begin
                  state_nxt = PAUSE;
               end
            end
            PAUSE: begin
               if (start_ev && door_closed) state_nxt = COOK;
            end
            DONE: begin
               time_nxt = '0;
               if (key_valid || !door_closed) state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               time_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      cooking = (state == COOK);
      paused  = (state == PAUSE);
   end

`ifdef COOK_POWER_LEVEL_EN
   localparam int SLOT_TICKS = TICKS_PER_SEC / SLOTS_PER_SEC;

   logic [3:0] level_q, level_nxt;

   assign level_nxt = (state_nxt == COOK && state != COOK) ? clamp_level(power_level) : level_q;
   // mag_on is registered, so gate on the slot the prescaler will be in next cycle.
   assign mag_nxt   = (state_nxt == COOK) &&
                      ((int'(presc_nxt) / SLOT_TICKS) < int'(level_nxt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= 4'(MAX_LEVEL);
      else     level_q <= level_nxt;
   end
`else
   logic unused_power;
   assign unused_power = ^power_level;
   assign mag_nxt      = (state_nxt == COOK);
`endif

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed self-checking bench for cook_sequencer at TICKS_PER_SEC=10.
module tb_cook_sequencer;

   logic        clk = 1'b0;
   logic        rst, startn, stopn, clrn, door_closed, key_valid;
   logic [3:0]  key_digit, power_level;
   logic        mag_on, timer_done, cooking, paused;
   logic [15:0] time_bcd;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;
   int mag_cnt;

   always #5 clk = ~clk;

   cook_sequencer #(.TICKS_PER_SEC(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .startn      (startn),
      .stopn       (stopn),
      .clrn        (clrn),
      .door_closed (door_closed),
      .key_valid   (key_valid),
      .key_digit   (key_digit),
      .power_level (power_level),
      .mag_on      (mag_on),
      .time_bcd    (time_bcd),
      .timer_done  (timer_done),
      .cooking     (cooking),
      .paused      (paused)
   );

   always @(negedge clk) if (timer_done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic start_press();
      startn = 1'b0;
      tick();
      startn = 1'b1;
   endtask

   task automatic clear();
      clrn = 1'b0;
      tick();
      clrn = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; startn = 1'b1; stopn = 1'b1; clrn = 1'b1; door_closed = 1'b1;
      key_valid = 1'b0; key_digit = 4'd0; power_level = 4'd10;
      tick(2);
      rst = 1'b0;
      tick();
      chk("rst_mag",  32'(mag_on), 0);
      chk("rst_time", 32'(time_bcd), 0);
      chk("rst_done", 32'(timer_done), 0);
      chk("rst_cook", 32'(cooking), 0);
      chk("rst_paus", 32'(paused), 0);

      // 1: 00:03 countdown to DONE
      key(0); key(0); key(0); key(3);
      chk("t1_entry", 32'(time_bcd), 32'h0003);
      start_press();
      chk("t1_mag_on", 32'(mag_on), 1);
      chk("t1_cooking", 32'(cooking), 1);
      tick(9);
      chk("t1_hold", 32'(time_bcd), 32'h0003);
      tick();
      chk("t1_t2", 32'(time_bcd), 32'h0002);
      tick(10);
      chk("t1_t1", 32'(time_bcd), 32'h0001);
      tick(9);
      chk("t1_done_early", 32'(timer_done), 0);
      tick();
      chk("t1_t0", 32'(time_bcd), 32'h0000);
      chk("t1_done", 32'(timer_done), 1);
      chk("t1_mag_off", 32'(mag_on), 0);
      chk("t1_not_cook", 32'(cooking), 0);
      tick();
      chk("t1_done_pulse", 32'(timer_done), 0);
      chk("t1_done_cnt", 32'(done_cnt), 1);
      key(7);
      chk("t1_exit_noload", 32'(time_bcd), 0);
      key(4);
      chk("t1_idle_load", 32'(time_bcd), 32'h0004);
      clear();

      // 2: minute borrow, s10 reload
      key(0); key(1); key(0); key(0);
      start_press();
      tick(50);
      chk("t2_0055", 32'(time_bcd), 32'h0055);
      stopn = 1'b0;
      tick();
      stopn = 1'b1;
      chk("t2_stop_paused", 32'(paused), 1);
      chk("t2_stop_mag", 32'(mag_on), 0);
      chk("t2_stop_time", 32'(time_bcd), 32'h0055);
      clear();
      chk("t2_clr_time", 32'(time_bcd), 0);
      chk("t2_clr_state", 32'({cooking, paused}), 0);

      // 3: door open at prescaler 4, resume from held prescaler
      key(0); key(0); key(1); key(0);
      start_press();
      tick(4);
      door_closed = 1'b0;
      tick();
      chk("t3_paused", 32'(paused), 1);
      chk("t3_mag", 32'(mag_on), 0);
      chk("t3_time", 32'(time_bcd), 32'h0010);
      door_closed = 1'b1;
      tick();
      start_press();
      chk("t3_resume", 32'(cooking), 1);
      tick(5);
      chk("t3_hold", 32'(time_bcd), 32'h0010);
      tick();
      chk("t3_dec", 32'(time_bcd), 32'h0009);

      // 4: held start does not retrigger; stop beats start
      door_closed = 1'b0;
      tick();
      startn = 1'b0;
      tick(20);
      chk("t4_door_open", 32'(paused), 1);
      door_closed = 1'b1;
      tick(2);
      chk("t4_held_start", 32'(paused), 1);
      startn = 1'b1;
      tick();
      start_press();
      chk("t4_restart", 32'(cooking), 1);
      tick();
      startn = 1'b0; stopn = 1'b0;
      tick();
      startn = 1'b1; stopn = 1'b1;
      chk("t4_stop_wins", 32'(paused), 1);
      chk("t4_stop_mag", 32'(mag_on), 0);
      clear();

`ifdef COOK_POWER_LEVEL_EN
      // 5: power level duty cycle
      power_level = 4'd3;
      key(0); key(0); key(0); key(5);
      start_press();
      mag_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (mag_on) mag_cnt++;
         tick();
      end
      chk("t5_level3", 32'(mag_cnt), 3);
      clear();
      power_level = 4'd0;
      key(0); key(0); key(0); key(5);
      start_press();
      mag_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (mag_on) mag_cnt++;
         tick();
      end
      chk("t5_level0", 32'(mag_cnt), 10);
      clear();
`endif

      // 6: async reset mid-cook, zero time start, digit range, shift-out
      key(0); key(0); key(0); key(5);
      start_press();
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_mag", 32'(mag_on), 0);
      chk("t6_rst_time", 32'(time_bcd), 0);
      chk("t6_rst_cook", 32'(cooking), 0);
      tick();
      rst = 1'b0;
      tick();
      key(4'hA);
      chk("t6_bad_digit", 32'(time_bcd), 0);
      key(1); key(2); key(3); key(4); key(5);
      chk("t6_shift", 32'(time_bcd), 32'h2345);
      clear();
      key(0); key(0); key(0); key(0);
      start_press();
      chk("t6_zero_start_mag", 32'(mag_on), 0);
      chk("t6_zero_start_cook", 32'(cooking), 0);
      tick(2);
      chk("t6_zero_still_idle", 32'({cooking, paused, mag_on}), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
